// File: rtl/dense_pkg.sv
// Shared types and sizing helpers for the dense-layer MAC.
// Covers the FSM state encoding, accumulator width and rounding guard.
package dense_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        FINISH,
        HOLD
    } state_t;

    // Headroom bit so bias and rounding terms cannot wrap the accumulator.
    localparam int SAT_GUARD = 1;

    function automatic int acc_w(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    function automatic int idx_w(input int n_in);
        return (n_in > 1) ? $clog2(n_in) : 1;
    endfunction

endpackage

// File: rtl/dense_round_sat.sv
// Combinational bias add, round-half-up, shift, saturate and optional ReLU.
// One instance per output neuron.
module dense_round_sat
    import dense_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int NFRAC = 14,
    parameter int ACC_W = 61,
    parameter int RELU  = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [WIDTH-1:0] bias,
    output logic        [WIDTH-1:0] y
);

    localparam int SW = ACC_W + SAT_GUARD;

    localparam logic signed [SW-1:0] HALF =
        SW'(1) <<< (NFRAC - 1);
    localparam logic signed [SW-1:0] SMAX =
        {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN =
        {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shf;
    logic        [WIDTH-1:0] sat;

    assign sum = SW'(acc) + (SW'(bias) <<< NFRAC) + HALF;
    assign shf = sum >>> NFRAC;

    always_comb begin
        sat = shf[WIDTH-1:0];
        if (shf > SMAX) begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (shf < SMIN) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end
        y = sat;
        if (RELU != 0 && sat[WIDTH-1]) begin
            y = '0;
        end
    end

endmodule

// File: rtl/dense_layer_mac.sv
// Streaming fully-connected layer: one feature per beat, N_OUT parallel MACs.
// Results are rounded, saturated and held until the consumer takes them.
module dense_layer_mac
    import dense_pkg::*;
#(
    parameter int N_IN  = 32,
    parameter int N_OUT = 5,
    parameter int WIDTH = 28,
    parameter int NFRAC = 14,
    parameter int RELU  = 0,
    parameter logic signed [WIDTH-1:0] WEIGHTS [N_IN][N_OUT] =
        '{default: '0},
    parameter logic signed [WIDTH-1:0] BIAS [N_OUT] =
        '{default: '0}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic signed [WIDTH-1:0]      in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N_OUT-1:0][WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int ACC_W = acc_w(WIDTH, N_IN);
    localparam int IDX_W = idx_w(N_IN);
    localparam int PW    = 2 * WIDTH;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc  [N_OUT];
    logic signed [PW-1:0]    prod [N_OUT];
    logic [N_OUT-1:0][WIDTH-1:0] res;

    logic run;
    logic in_fire;
    logic out_fire;
    logic last;

    assign in_fire  = in_valid && in_ready && !clear;
    assign out_fire = out_valid && out_ready && !clear;
    assign last     = (idx == IDX_W'(N_IN - 1));

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ACCUM;
        end else begin
            unique case (state)
                ACCUM:   if (in_fire && last) state_nx = FINISH;
                FINISH:  state_nx = HOLD;
                HOLD:    if (out_fire) state_nx = ACCUM;
                default: state_nx = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM:   in_ready  = run;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = PW'(in_data) * PW'(WEIGHTS[idx][j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else if (clear || out_fire) begin
            idx <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else if (in_fire) begin
            idx <= last ? '0 : idx + IDX_W'(1);
            for (int j = 0; j < N_OUT; j++) begin
                acc[j] <= acc[j] + ACC_W'(prod[j]);
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_rs
        dense_round_sat #(
            .WIDTH (WIDTH),
            .NFRAC (NFRAC),
            .ACC_W (ACC_W),
            .RELU  (RELU)
        ) u_rs (
            .acc  (acc[j]),
            .bias (BIAS[j]),
            .y    (res[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (state == FINISH && !clear) begin
            out_data <= res;
        end
    end

endmodule
